csr_access_unit: RTL
====================

// Module: csr_access_unit
// PURPOSE
//   Initiator side of the CSR write/read interface. Executes Zicsr ops
//   (CSRRW/RS/RC, imm forms pre-resolved), trap entry and MRET. Sequences
//   single-port writes into the machine CSR file; returns old value or redirect.
//   Sits between execute stage (req/resp handshake) and the CSR register file.
// PARAMETERS
//   XLEN        64     data width; equals csr_t width
//   VECTORED_EN 1      1: honour mtvec.MODE==1 for interrupts; 0: always direct
// PORTS
//   clk              in   1     clock
//   rst_n            in   1     reset, asynchronous, active-low
//   req_valid        in   1     request present
//   req_ready        out  1     unit idle, request accepted when valid&ready
//   req_op           in   3     csr_op_t: RW, RS, RC, TRAP, MRET
//   req_addr         in   12    CSR address (RW/RS/RC)
//   req_wdata        in   XLEN  rs1 value or zero-extended zimm
//   req_no_write     in   1     rs1/zimm field is 0 (suppresses RS/RC write)
//   req_pc           in   XLEN  faulting pc (TRAP)
//   req_cause        in   XLEN  mcause value, bit XLEN-1 = interrupt (TRAP)
//   req_tval         in   XLEN  mtval value (TRAP)
//   resp_valid       out  1     response present, held until resp_ready
//   resp_ready       in   1     consumer accepts response
//   resp_rdata       out  XLEN  old CSR value (RW/RS/RC), else 0
//   resp_illegal     out  1     unimplemented addr or write to read-only CSR
//   resp_redirect    out  1     TRAP/MRET: fetch must jump to resp_target
//   resp_target      out  XLEN  redirect pc
//   csr              in   csr_pack  current CSR state
//   csr_write_enable out  1     one-cycle write strobe
//   csr_addr         out  12    write address
//   csr_write_data   out  XLEN  raw write data (file applies masks)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_*=0;
//     csr_write_enable=0, csr_addr=0, csr_write_data=0. Reset mid-sequence
//     aborts it; partially written trap CSRs stay as written.
//   States: IDLE -> ACCESS -> RESP; IDLE -> T_EPC -> T_CAUSE -> T_TVAL ->
//     T_STATUS -> RESP; IDLE -> M_STATUS -> RESP; RESP -> IDLE on resp_ready.
//   req_ready=1 only in IDLE; request fields latched on accept.
//   ACCESS (1 cycle): old=decode(csr,addr); new = RW:wdata, RS:old|wdata,
//     RC:old&~wdata. Write strobe iff legal and !(RS/RC & no_write).
//     Illegal: addr unimplemented, or write attempted with addr[11:10]==2'b11;
//     illegal -> no strobe, resp_rdata=0, resp_illegal=1.
//   Latency RW/RS/RC: accept cycle N, strobe N+1, resp_valid N+2.
//   TRAP: strobes mepc=pc&~1, mcause, mtval, mstatus on 4 consecutive cycles.
//     mstatus new: MPIE(7)=old MIE(3), MIE=0, MPP(12:11)=2'b11; others kept.
//     target = mtvec&~3; if VECTORED_EN & mtvec[1:0]==1 & cause[XLEN-1]:
//     target += 4*cause[XLEN-2:0] (XLEN-wrap). resp_valid on 5th cycle.
//   MRET: one strobe to mstatus: MIE=MPIE, MPIE=1, MPP=2'b11; target=mepc
//     sampled in M_STATUS. Response on following cycle.
//   csr_write_enable high exactly one cycle per strobe; never in IDLE/RESP.
//   Reads in a state see csr input as of that cycle (prior strobes visible).
//   Response outputs stable while resp_valid & !resp_ready.
//   Unused op encodings: treated as illegal RW, no strobe.
// STRUCTURE
//   csr_pkg: csr_op_t enum, CSR_* addresses, MSTATUS bit positions.
//   Read decode via shared csr_selector sub-module (addr -> value, hit flag
//   derived from same address list). FSM + datapath in this module.
// TESTING
//   1 RW mscratch, wdata=0xDEAD, mscratch=0x5 -> strobe 0x341? no: addr
//     0x340 data 0xDEAD at N+1; rdata=0x5 at N+2.
//   2 RS mstatus, no_write=1, mstatus=0x88 -> no strobe, rdata=0x88;
//     RC mie, wdata=0x8, mie=0x888 -> strobe data 0x880.
//   3 RW mhartid (0xF14) -> no strobe, resp_illegal=1; RW 0x7C0 -> illegal.
//   4 TRAP pc=0x8000_0104, cause=2, tval=0x13, mstatus=0x8, mtvec=0x8000_0001
//     -> strobes 0x341/0x342/0x343/0x300 data 0x1880; target=0x8000_0000.
//   5 TRAP cause=(1<<63)|7, mtvec=0x8000_0001 -> target 0x8000_001C;
//     MRET, mstatus=0x1880, mepc=0x104 -> strobe 0x300 data 0x1888, target 0x104.
//   6 rst_n low during T_CAUSE -> strobe drops at once, req_ready=1;
//     resp_valid held 3 cycles with resp_ready=0 -> outputs unchanged.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// Shared types, CSR addresses and mstatus helpers for the CSR access unit.
package csr_access_unit_pkg;

    localparam int XLEN = 64;

    typedef logic [XLEN-1:0] csr_t;

    typedef enum logic [2:0] {
        OP_RW   = 3'd0,
        OP_RS   = 3'd1,
        OP_RC   = 3'd2,
        OP_TRAP = 3'd3,
        OP_MRET = 3'd4
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Snapshot of the machine CSR file as seen by the unit.
    typedef struct packed {
        csr_t mstatus;
        csr_t misa;
        csr_t mie;
        csr_t mtvec;
        csr_t mscratch;
        csr_t mepc;
        csr_t mcause;
        csr_t mtval;
        csr_t mip;
        csr_t mvendorid;
        csr_t marchid;
        csr_t mimpid;
        csr_t mhartid;
    } csr_pack;

    // Request fields held for the duration of a sequence.
    typedef struct packed {
        csr_op_t     op;
        logic [11:0] addr;
        csr_t        wdata;
        logic        no_write;
        csr_t        pc;
        csr_t        cause;
        csr_t        tval;
    } csr_req_t;

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode.
    function automatic csr_t mstatus_trap(input csr_t old);
        csr_t n;
        n = old;
        n[MSTATUS_MPIE] = old[MSTATUS_MIE];
        n[MSTATUS_MIE]  = 1'b0;
        n[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return n;
    endfunction

    // MRET: restore MIE from MPIE, set MPIE, MPP stays M (only mode here).
    function automatic csr_t mstatus_mret(input csr_t old);
        csr_t n;
        n = old;
        n[MSTATUS_MIE]  = old[MSTATUS_MPIE];
        n[MSTATUS_MPIE] = 1'b1;
        n[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return n;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between execute stage and the CSR access unit.
interface csr_access_unit_if import csr_access_unit_pkg::*; ();

    logic        req_valid;
    logic        req_ready;
    csr_op_t     req_op;
    logic [11:0] req_addr;
    csr_t        req_wdata;
    logic        req_no_write;
    csr_t        req_pc;
    csr_t        req_cause;
    csr_t        req_tval;

    logic        resp_valid;
    logic        resp_ready;
    csr_t        resp_rdata;
    logic        resp_illegal;
    logic        resp_redirect;
    csr_t        resp_target;

    // Execute stage side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_no_write,
               req_pc, req_cause, req_tval, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_illegal,
               resp_redirect, resp_target
    );

    // CSR access unit side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_no_write,
               req_pc, req_cause, req_tval, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_illegal,
               resp_redirect, resp_target
    );

endinterface

// File: rtl/csr_access_unit_csr_selector.sv
// Read decode: selects a CSR value by address. The hit flag comes from the
// same case arms so the implemented-address list exists in one place only.
module csr_access_unit_csr_selector import csr_access_unit_pkg::*; (
    input  csr_pack     csr_i,
    input  logic [11:0] addr_i,
    output csr_t        value_o,
    output logic        hit_o
);

    // Address mux with implemented flag.
    always_comb begin
        value_o = '0;
        hit_o   = 1'b1;
        case (addr_i)
            CSR_MSTATUS:   value_o = csr_i.mstatus;
            CSR_MISA:      value_o = csr_i.misa;
            CSR_MIE:       value_o = csr_i.mie;
            CSR_MTVEC:     value_o = csr_i.mtvec;
            CSR_MSCRATCH:  value_o = csr_i.mscratch;
            CSR_MEPC:      value_o = csr_i.mepc;
            CSR_MCAUSE:    value_o = csr_i.mcause;
            CSR_MTVAL:     value_o = csr_i.mtval;
            CSR_MIP:       value_o = csr_i.mip;
            CSR_MVENDORID: value_o = csr_i.mvendorid;
            CSR_MARCHID:   value_o = csr_i.marchid;
            CSR_MIMPID:    value_o = csr_i.mimpid;
            CSR_MHARTID:   value_o = csr_i.mhartid;
            default:       hit_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: runs Zicsr read-modify-write, trap entry and MRET as
// short sequences of single-port writes into the machine CSR file.
module csr_access_unit import csr_access_unit_pkg::*; #(
    parameter int XLEN        = csr_access_unit_pkg::XLEN,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    csr_access_unit_if.slave   bus,
    input  csr_pack            csr,
    output logic               csr_write_enable,
    output logic [11:0]        csr_addr,
    output logic [XLEN-1:0]    csr_write_data
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCESS   = 3'd1;
    localparam logic [2:0] S_T_EPC    = 3'd2;
    localparam logic [2:0] S_T_CAUSE  = 3'd3;
    localparam logic [2:0] S_T_TVAL   = 3'd4;
    localparam logic [2:0] S_T_STATUS = 3'd5;
    localparam logic [2:0] S_M_STATUS = 3'd6;
    localparam logic [2:0] S_RESP     = 3'd7;

    logic [2:0]      state_q, state_d;
    csr_req_t        req_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            illegal_q, illegal_d;
    logic            redirect_q, redirect_d;

    logic [XLEN-1:0] old_val, new_val, tvec_base, trap_target;
    logic            hit, is_rs, is_rc, is_known, wr_try, acc_illegal, vec_hit;

    csr_access_unit_csr_selector u_sel (
        .csr_i   (csr),
        .addr_i  (req_q.addr),
        .value_o (old_val),
        .hit_o   (hit)
    );

    // Zicsr decode; any unknown op is handled as a write attempt (illegal RW).
    assign is_rs       = (req_q.op == OP_RS);
    assign is_rc       = (req_q.op == OP_RC);
    assign is_known    = (req_q.op == OP_RW) | is_rs | is_rc;
    assign wr_try      = !(is_rs | is_rc) | !req_q.no_write;
    assign acc_illegal = !is_known | !hit | (wr_try & (req_q.addr[11:10] == 2'b11));
    assign new_val     = is_rs ? (old_val | req_q.wdata) :
                         is_rc ? (old_val & ~req_q.wdata) : req_q.wdata;

    // Vector offset 4*cause[XLEN-2:0] modulo 2^XLEN drops cause[XLEN-2].
    assign tvec_base   = {csr.mtvec[XLEN-1:2], 2'b00};
    assign vec_hit     = VECTORED_EN && (csr.mtvec[1:0] == 2'b01) && req_q.cause[XLEN-1];
    assign trap_target = vec_hit ? tvec_base + {req_q.cause[XLEN-3:0], 2'b00} : tvec_base;

    // Sequencer: next state, write strobe and response capture.
    always_comb begin
        state_d          = state_q;
        rdata_d          = rdata_q;
        target_d         = target_q;
        illegal_d        = illegal_q;
        redirect_d       = redirect_q;
        csr_write_enable = 1'b0;
        csr_addr         = '0;
        csr_write_data   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_TRAP: state_d = S_T_EPC;
                        OP_MRET: state_d = S_M_STATUS;
                        default: state_d = S_ACCESS;
                    endcase
                end
            end
            S_ACCESS: begin
                if (!acc_illegal && wr_try) begin
                    csr_write_enable = 1'b1;
                    csr_addr         = req_q.addr;
                    csr_write_data   = new_val;
                end
                rdata_d    = acc_illegal ? '0 : old_val;
                illegal_d  = acc_illegal;
                redirect_d = 1'b0;
                target_d   = '0;
                state_d    = S_RESP;
            end
            S_T_EPC: begin
                csr_write_enable = 1'b1;
                csr_addr         = CSR_MEPC;
                csr_write_data   = {req_q.pc[XLEN-1:1], 1'b0};
                state_d          = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_write_enable = 1'b1;
                csr_addr         = CSR_MCAUSE;
                csr_write_data   = req_q.cause;
                state_d          = S_T_TVAL;
            end
            S_T_TVAL: begin
                csr_write_enable = 1'b1;
                csr_addr         = CSR_MTVAL;
                csr_write_data   = req_q.tval;
                state_d          = S_T_STATUS;
            end
            S_T_STATUS: begin
                csr_write_enable = 1'b1;
                csr_addr         = CSR_MSTATUS;
                csr_write_data   = mstatus_trap(csr.mstatus);
                rdata_d          = '0;
                illegal_d        = 1'b0;
                redirect_d       = 1'b1;
                target_d         = trap_target;
                state_d          = S_RESP;
            end
            S_M_STATUS: begin
                csr_write_enable = 1'b1;
                csr_addr         = CSR_MSTATUS;
                csr_write_data   = mstatus_mret(csr.mstatus);
                rdata_d          = '0;
                illegal_d        = 1'b0;
                redirect_d       = 1'b1;
                target_d         = csr.mepc;
                state_d          = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rdata_q    <= '0;
            target_q   <= '0;
            illegal_q  <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            target_q   <= target_d;
            illegal_q  <= illegal_d;
            redirect_q <= redirect_d;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (state_q == S_IDLE && bus.req_valid) begin
            req_q <= '{op: bus.req_op, addr: bus.req_addr, wdata: bus.req_wdata,
                       no_write: bus.req_no_write, pc: bus.req_pc,
                       cause: bus.req_cause, tval: bus.req_tval};
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.resp_valid    = (state_q == S_RESP);
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_illegal  = illegal_q;
    assign bus.resp_redirect = redirect_q;
    assign bus.resp_target   = target_q;

endmodule
